// File: rtl/gamepad_pmod_pkg.sv
`default_nettype none
// ============================================================================
// Module : gamepad_pmod_pkg
// Brief  : Shared constants, button indices and helpers for the Pmod receiver.
// Rev    : 1.0  initial release
// ============================================================================
package gamepad_pmod_pkg;

  localparam int C_PAD_BITS = 12;
  localparam logic [C_PAD_BITS-1:0] C_ABSENT = 12'hFFF;

  typedef enum logic [3:0] {
    BTN_R     = 4'd0,
    BTN_L     = 4'd1,
    BTN_X     = 4'd2,
    BTN_A     = 4'd3,
    BTN_RT    = 4'd4,
    BTN_LT    = 4'd5,
    BTN_DN    = 4'd6,
    BTN_UP    = 4'd7,
    BTN_START = 4'd8,
    BTN_SEL   = 4'd9,
    BTN_Y     = 4'd10,
    BTN_B     = 4'd11
  } btn_idx_e;

  // An unplugged pad leaves the data line pulled high for its whole slot.
  function automatic logic pad_present(input logic [C_PAD_BITS-1:0] slice);
    return slice != C_ABSENT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gamepad_pmod_multi_if.sv
`default_nettype none
// ============================================================================
// Module : gamepad_pmod_multi_if
// Brief  : Pmod pin inputs and decoded controller outputs of the receiver.
// Rev    : 1.0  initial release
// ============================================================================
interface gamepad_pmod_multi_if
  import gamepad_pmod_pkg::*;
#(
  parameter int NUM_PADS = 2
) ();

  logic                           pmod_data;
  logic                           pmod_clk;
  logic                           pmod_latch;
  logic [NUM_PADS*C_PAD_BITS-1:0] buttons;
  logic [NUM_PADS*C_PAD_BITS-1:0] pressed;
  logic [NUM_PADS*C_PAD_BITS-1:0] released;
  logic [NUM_PADS-1:0]            is_present;
  logic                           frame_valid;
  logic                           frame_error;
  logic                           link_alive;

  modport master (
    output pmod_data, pmod_clk, pmod_latch,
    input  buttons, pressed, released, is_present,
    input  frame_valid, frame_error, link_alive
  );

  modport slave (
    input  pmod_data, pmod_clk, pmod_latch,
    output buttons, pressed, released, is_present,
    output frame_valid, frame_error, link_alive
  );

endinterface
`default_nettype wire

// File: rtl/gamepad_pmod_pad_decode.sv
`default_nettype none
// ============================================================================
// Module : gamepad_pmod_pad_decode
// Brief  : Per-pad presence, masking, registered buttons and edge events.
// Rev    : 1.0  initial release
// ============================================================================
module gamepad_pmod_pad_decode
  import gamepad_pmod_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [C_PAD_BITS-1:0] slice,
  output logic [C_PAD_BITS-1:0] buttons,
  output logic [C_PAD_BITS-1:0] pressed,
  output logic [C_PAD_BITS-1:0] released,
  output logic                  is_present
);

  logic                  w_present;
  logic [C_PAD_BITS-1:0] w_new;

  assign w_present = pad_present(slice);
  assign w_new     = w_present ? slice : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buttons    <= '0;
      pressed    <= '0;
      released   <= '0;
      is_present <= 1'b0;
    end else begin
      pressed  <= '0;
      released <= '0;
      if (load) begin
        buttons    <= w_new;
        is_present <= w_present;
        pressed    <= w_new & ~buttons;
        released   <= ~w_new & buttons;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gamepad_pmod_multi.sv
`default_nettype none
// ============================================================================
// Module : gamepad_pmod_multi
// Brief  : Daisy-chained Gamepad Pmod receiver with framing check and watchdog.
// Rev    : 1.0  initial release
// ============================================================================
module gamepad_pmod_multi
  import gamepad_pmod_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int PAD_BITS    = C_PAD_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gamepad_pmod_multi_if.slave  bus
);

  localparam int                   C_FRAME_BITS = NUM_PADS * PAD_BITS;
  localparam int                   C_CNT_W      = $clog2(C_FRAME_BITS + 2);
  localparam logic [C_CNT_W-1:0]   C_CNT_FULL   = C_CNT_W'(C_FRAME_BITS);
  localparam logic [C_CNT_W-1:0]   C_CNT_SAT    = C_CNT_W'(C_FRAME_BITS + 1);
  localparam logic [TIMEOUT_W-1:0] C_WDOG_MAX   = '1;
  localparam logic [TIMEOUT_W-1:0] C_WDOG_LAST  = C_WDOG_MAX - TIMEOUT_W'(1);

  logic [SYNC_STAGES-1:0]  r_sync_data, r_sync_clk, r_sync_latch;
  logic                    r_clk_prev, r_latch_prev;
  logic [C_FRAME_BITS-1:0] r_shift;
  logic [C_CNT_W-1:0]      r_bit_cnt;
  logic [TIMEOUT_W-1:0]    r_wdog;
  logic                    r_frame_valid, r_frame_error, r_link_alive;

  logic                    w_data, w_clk_rise, w_latch_rise;
  logic                    w_good, w_bad, w_timeout, w_load;
  logic [C_FRAME_BITS-1:0] w_load_data;
  logic [C_FRAME_BITS-1:0] w_buttons, w_pressed, w_released;
  logic [NUM_PADS-1:0]     w_present;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync_data  <= '0;
      r_sync_clk   <= '0;
      r_sync_latch <= '0;
      r_clk_prev   <= 1'b0;
      r_latch_prev <= 1'b0;
    end else begin
      r_sync_data  <= {r_sync_data[SYNC_STAGES-2:0], bus.pmod_data};
      r_sync_clk   <= {r_sync_clk[SYNC_STAGES-2:0], bus.pmod_clk};
      r_sync_latch <= {r_sync_latch[SYNC_STAGES-2:0], bus.pmod_latch};
      r_clk_prev   <= r_sync_clk[SYNC_STAGES-1];
      r_latch_prev <= r_sync_latch[SYNC_STAGES-1];
    end
  end

  assign w_data       = r_sync_data[SYNC_STAGES-1];
  assign w_clk_rise   = r_sync_clk[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_latch_rise = r_sync_latch[SYNC_STAGES-1] & ~r_latch_prev;

  // A good latch wins over a coincident timeout; the commit reads the pre-shift register.
  assign w_good      = w_latch_rise && (r_bit_cnt == C_CNT_FULL);
  assign w_bad       = w_latch_rise && !w_good;
  assign w_timeout   = !w_good && (r_wdog == C_WDOG_LAST);
  assign w_load      = w_good || w_timeout;
  assign w_load_data = w_good ? r_shift : '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_wdog        <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_link_alive  <= 1'b0;
    end else begin
      r_frame_valid <= w_good;
      r_frame_error <= w_bad;
      if (w_clk_rise)
        r_shift <= {r_shift[C_FRAME_BITS-2:0], w_data};
      if (w_latch_rise)
        r_bit_cnt <= w_clk_rise ? C_CNT_W'(1) : '0;
      else if (w_clk_rise && (r_bit_cnt != C_CNT_SAT))
        r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
      if (w_good)
        r_wdog <= '0;
      else if (r_wdog != C_WDOG_MAX)
        r_wdog <= r_wdog + TIMEOUT_W'(1);
      if (w_good)
        r_link_alive <= 1'b1;
      else if (w_timeout)
        r_link_alive <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    gamepad_pmod_pad_decode u_decode (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (w_load),
      .slice      (w_load_data[g*PAD_BITS +: PAD_BITS]),
      .buttons    (w_buttons[g*PAD_BITS +: PAD_BITS]),
      .pressed    (w_pressed[g*PAD_BITS +: PAD_BITS]),
      .released   (w_released[g*PAD_BITS +: PAD_BITS]),
      .is_present (w_present[g])
    );
  end

  assign bus.buttons     = w_buttons;
  assign bus.pressed     = w_pressed;
  assign bus.released    = w_released;
  assign bus.is_present  = w_present;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_error = r_frame_error;
  assign bus.link_alive  = r_link_alive;

endmodule
`default_nettype wire

// File: tb/tb_gamepad_pmod_multi.sv
`default_nettype none
// Testbench for gamepad_pmod_multi: serial frames driven on the Pmod pins and
// checked against a frame-level model of committed pad state.
module tb_gamepad_pmod_multi;

  localparam int NP = 2;
  localparam int FB = NP * 12;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gamepad_pmod_multi_if #(.NUM_PADS(NP)) bus ();

  gamepad_pmod_multi #(
    .NUM_PADS(NP), .PAD_BITS(12), .SYNC_STAGES(2), .TIMEOUT_W(TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Observation accumulators, cleared by each scenario before its stimulus.
  int            fv_cnt, fe_cnt, press_cyc, rel_cyc;
  logic [FB-1:0] acc_p, acc_r, snap_btn;
  logic [NP-1:0] snap_pres;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_cnt++;
      snap_btn  = bus.buttons;
      snap_pres = bus.is_present;
    end
    if (bus.frame_error === 1'b1) fe_cnt++;
    if (bus.pressed !== '0) begin press_cyc++; acc_p |= bus.pressed; end
    if (bus.released !== '0) begin rel_cyc++; acc_r |= bus.released; end
  end

  // Reference model: bits received since last latch, and decoded pad state.
  bit            m_q[$];
  logic [FB-1:0] m_btn, m_exp_p, m_exp_r;
  logic [NP-1:0] m_pres;
  bit            m_good;

  task automatic clear_acc();
    fv_cnt = 0; fe_cnt = 0; press_cyc = 0; rel_cyc = 0;
    acc_p = '0; acc_r = '0; snap_btn = '0; snap_pres = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    bus.pmod_data = b;
    tick(2);
    bus.pmod_clk = 1'b1;
    tick(2);
    bus.pmod_clk = 1'b0;
    tick(2);
    m_q.push_back(b);
  endtask

  task automatic send_bits(input logic [FB-1:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(f[i]);
  endtask

  // First bit received is the frame MSB; each 12-bit slot is one pad.
  task automatic model_latch();
    logic [FB-1:0] f, nb;
    logic [NP-1:0] np;
    m_good  = (m_q.size() == FB);
    m_exp_p = '0;
    m_exp_r = '0;
    if (m_good) begin
      for (int i = 0; i < FB; i++) f[FB-1-i] = m_q[i];
      for (int k = 0; k < NP; k++) begin
        np[k] = (f[12*k +: 12] != 12'hFFF);
        nb[12*k +: 12] = np[k] ? f[12*k +: 12] : 12'h000;
      end
      m_exp_p = nb & ~m_btn;
      m_exp_r = ~nb & m_btn;
      m_btn   = nb;
      m_pres  = np;
    end
    m_q.delete();
  endtask

  task automatic do_latch();
    bus.pmod_latch = 1'b1;
    tick(2);
    bus.pmod_latch = 1'b0;
    tick(8);
    model_latch();
  endtask

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] f;
    for (int k = 0; k < NP; k++)
      f[12*k +: 12] = ($urandom_range(3) == 0) ? 12'hFFF : 12'($urandom);
    return f;
  endfunction

  task automatic test_reset();
    tick(5);
    checks++; if (bus.buttons !== '0) begin errors++; $display("FAIL reset_buttons got=%h want=0", bus.buttons); end
    checks++; if (bus.is_present !== '0) begin errors++; $display("FAIL reset_present got=%b want=0", bus.is_present); end
    checks++; if ({bus.pressed, bus.released} !== '0) begin errors++; $display("FAIL reset_events got=%h want=0", {bus.pressed, bus.released}); end
    checks++; if ({bus.frame_valid, bus.frame_error, bus.link_alive} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {bus.frame_valid, bus.frame_error, bus.link_alive}); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_basic_press();
    clear_acc();
    send_bits({12'hFFF, 12'h008}, FB);
    do_latch();
    checks++; if (bus.buttons !== 24'h000008) begin errors++; $display("FAIL basic_buttons got=%h want=000008", bus.buttons); end
    checks++; if (bus.is_present !== 2'b01) begin errors++; $display("FAIL basic_present got=%b want=01", bus.is_present); end
    checks++; if (acc_p !== 24'h000008 || press_cyc != 1) begin errors++; $display("FAIL basic_pressed got=%h/%0d cycles want=000008/1", acc_p, press_cyc); end
    checks++; if (fv_cnt != 1 || snap_btn !== 24'h000008) begin errors++; $display("FAIL basic_valid got=%0d pulses btn=%h want=1 pulse btn=000008", fv_cnt, snap_btn); end
    checks++; if (bus.link_alive !== 1'b1) begin errors++; $display("FAIL basic_alive got=%b want=1", bus.link_alive); end
  endtask

  task automatic test_release();
    clear_acc();
    send_bits({12'hFFF, 12'h000}, FB);
    do_latch();
    checks++; if (acc_r !== 24'h000008 || rel_cyc != 1) begin errors++; $display("FAIL release_pulse got=%h/%0d cycles want=000008/1", acc_r, rel_cyc); end
    checks++; if (press_cyc != 0) begin errors++; $display("FAIL release_press_quiet got=%0d cycles want=0", press_cyc); end
    checks++; if (bus.is_present !== 2'b01 || bus.buttons !== '0) begin errors++; $display("FAIL release_state got=%b/%h want=01/000000", bus.is_present, bus.buttons); end
  endtask

  task automatic test_random_frames();
    logic [FB-1:0] f;
    for (int n = 0; n < 8; n++) begin
      f = rand_frame();
      clear_acc();
      send_bits(f, FB);
      do_latch();
      checks++; if (fv_cnt != 1 || fe_cnt != 0) begin errors++; $display("FAIL rand%0d_flags got=%0d valid %0d error want=1/0", n, fv_cnt, fe_cnt); end
      checks++; if (bus.buttons !== m_btn || snap_btn !== m_btn) begin errors++; $display("FAIL rand%0d_buttons got=%h at_valid=%h want=%h", n, bus.buttons, snap_btn, m_btn); end
      checks++; if (bus.is_present !== m_pres || snap_pres !== m_pres) begin errors++; $display("FAIL rand%0d_present got=%b want=%b", n, bus.is_present, m_pres); end
      checks++; if (acc_p !== m_exp_p || press_cyc != ((m_exp_p != 0) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_pressed got=%h/%0d want=%h", n, acc_p, press_cyc, m_exp_p); end
      checks++; if (acc_r !== m_exp_r || rel_cyc != ((m_exp_r != 0) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_released got=%h/%0d want=%h", n, acc_r, rel_cyc, m_exp_r); end
    end
  endtask

  task automatic test_coincident();
    logic [FB-1:0] f1, f2;
    f1 = rand_frame();
    f2 = rand_frame();
    send_bits(f1, FB);
    clear_acc();
    bus.pmod_data = f2[FB-1];
    tick(2);
    bus.pmod_clk   = 1'b1;
    bus.pmod_latch = 1'b1;
    tick(2);
    bus.pmod_clk   = 1'b0;
    bus.pmod_latch = 1'b0;
    tick(8);
    model_latch();
    m_q.push_back(f2[FB-1]);
    checks++; if (fv_cnt != 1 || fe_cnt != 0 || bus.buttons !== m_btn) begin errors++; $display("FAIL coincident_commit got=%0d/%0d btn=%h want=1/0 btn=%h", fv_cnt, fe_cnt, bus.buttons, m_btn); end
    clear_acc();
    send_bits(f2, FB - 1);
    do_latch();
    checks++; if (fv_cnt != 1 || fe_cnt != 0) begin errors++; $display("FAIL coincident_next got=%0d valid %0d error want=1/0", fv_cnt, fe_cnt); end
    checks++; if (bus.buttons !== m_btn || bus.is_present !== m_pres) begin errors++; $display("FAIL coincident_next_data got=%h/%b want=%h/%b", bus.buttons, bus.is_present, m_btn, m_pres); end
  endtask

  task automatic test_reset_midframe();
    logic [FB-1:0] f;
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    clear_acc();
    rst_n = 1'b0;
    tick(3);
    m_q.delete();
    m_btn  = '0;
    m_pres = '0;
    checks++; if (bus.buttons !== '0 || bus.is_present !== '0 || bus.link_alive !== 1'b0) begin errors++; $display("FAIL inreset_outputs got=%h/%b/%b want=0/0/0", bus.buttons, bus.is_present, bus.link_alive); end
    checks++; if (press_cyc != 0 || rel_cyc != 0) begin errors++; $display("FAIL inreset_events got=%0d/%0d want=0/0", press_cyc, rel_cyc); end
    rst_n = 1'b1;
    tick(3);
    f = rand_frame();
    f[11:0] = (12'($urandom) & 12'h7FE) | 12'h001;
    clear_acc();
    send_bits(f, FB);
    do_latch();
    checks++; if (fe_cnt != 0 || fv_cnt != 1) begin errors++; $display("FAIL postreset_flags got=%0d valid %0d error want=1/0", fv_cnt, fe_cnt); end
    checks++; if (bus.buttons !== m_btn || bus.is_present !== m_pres) begin errors++; $display("FAIL postreset_data got=%h/%b want=%h/%b", bus.buttons, bus.is_present, m_btn, m_pres); end
    checks++; if (acc_p !== m_exp_p) begin errors++; $display("FAIL postreset_pressed got=%h want=%h", acc_p, m_exp_p); end
  endtask

  task automatic test_frame_error();
    logic [FB-1:0] keep_btn;
    logic [NP-1:0] keep_pres;
    keep_btn  = m_btn;
    keep_pres = m_pres;
    clear_acc();
    send_bits(rand_frame(), FB - 1);
    do_latch();
    checks++; if (fe_cnt != 1 || fv_cnt != 0) begin errors++; $display("FAIL short_flags got=%0d error %0d valid want=1/0", fe_cnt, fv_cnt); end
    checks++; if (bus.buttons !== keep_btn || bus.is_present !== keep_pres) begin errors++; $display("FAIL short_hold got=%h/%b want=%h/%b", bus.buttons, bus.is_present, keep_btn, keep_pres); end
    checks++; if (press_cyc != 0 || rel_cyc != 0) begin errors++; $display("FAIL short_events got=%0d/%0d want=0/0", press_cyc, rel_cyc); end
    checks++; if (bus.link_alive !== 1'b1) begin errors++; $display("FAIL short_alive got=%b want=1", bus.link_alive); end
  endtask

  task automatic test_timeout();
    logic [FB-1:0] held;
    held = m_btn;
    clear_acc();
    tick(1 << TW);
    tick(40);
    m_btn  = '0;
    m_pres = '0;
    checks++; if (bus.link_alive !== 1'b0) begin errors++; $display("FAIL timeout_alive got=%b want=0", bus.link_alive); end
    checks++; if (bus.is_present !== '0 || bus.buttons !== '0) begin errors++; $display("FAIL timeout_state got=%b/%h want=00/000000", bus.is_present, bus.buttons); end
    checks++; if (acc_r !== held || rel_cyc != ((held != 0) ? 1 : 0)) begin errors++; $display("FAIL timeout_released got=%h/%0d want=%h", acc_r, rel_cyc, held); end
    checks++; if (press_cyc != 0 || fv_cnt != 0 || fe_cnt != 0) begin errors++; $display("FAIL timeout_quiet got=%0d/%0d/%0d want=0/0/0", press_cyc, fv_cnt, fe_cnt); end
  endtask

  initial begin
    bus.pmod_data  = 1'b0;
    bus.pmod_clk   = 1'b0;
    bus.pmod_latch = 1'b0;
    m_btn  = '0;
    m_pres = '0;
    clear_acc();
    test_reset();
    test_basic_press();
    test_release();
    test_random_frames();
    test_coincident();
    test_reset_midframe();
    test_frame_error();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
